adder16_share_sched: RTL and testbench

//  Shares one carry_select_adder16 instance among NREQ requesters using round-robin arbitration.

---
 rtl/adder16_sched_pkg.sv | 43 ++++
 rtl/carry_select_adder16.sv | 30 +++
 rtl/rr_arb.sv | 28 ++
 rtl/adder16_share_sched.sv | 189 ++++++++++++++++++
 tb/tb_adder16_share_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder16_sched_pkg.sv
// Package for the shared 16-bit adder scheduler.
// Holds the word width, the scheduler state encoding and the round-robin
// pick function used by rr_arb.
package adder16_sched_pkg;

    localparam int WORD_W  = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0], searching upward from ptr and wrapping mod n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int unsigned        n
    );
        rr_pick_t    res;
        int unsigned j;
        logic [2:0]  jj;
        res.found = 1'b0;
        res.idx   = 3'd0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j  = ({29'd0, ptr} + k) % n;
                jj = 3'(j);
                if (valid[jj] && !res.found) begin
                    res.found = 1'b1;
                    res.idx   = jj;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/carry_select_adder16.sv
// 16-bit carry-select adder: the low byte ripples, the high byte is computed
// for both possible carries and the low-byte carry selects between them.
// Ports: a, b (16-bit operands), cin (carry in), sum (16-bit), cout (bit 16).
module carry_select_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [8:0] lo_s;
    logic [8:0] hi0_s;
    logic [8:0] hi1_s;

    // Low byte plus both speculative high-byte sums, then carry selection.
    always_comb begin
        lo_s  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
        hi0_s = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        hi1_s = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;
        if (lo_s[8]) begin
            sum  = {hi1_s[7:0], lo_s[7:0]};
            cout = hi1_s[8];
        end else begin
            sum  = {hi0_s[7:0], lo_s[7:0]};
            cout = hi0_s[8];
        end
    end

endmodule

// File: rtl/rr_arb.sv
// NREQ-way pointer-based priority picker (purely combinational).
// Ports: valid (request vector), ptr (highest-priority index),
//        found (any request present), idx (chosen requester).
module rr_arb
    import adder16_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [MAX_REQ-1:0] valid8_s;
    rr_pick_t           pick_s;

    // Widen the request vector to the function's fixed width and pick.
    always_comb begin
        valid8_s             = {MAX_REQ{1'b0}};
        valid8_s[NREQ-1:0]   = valid;
        pick_s               = rr_pick(valid8_s, 3'(ptr), unsigned'(NREQ));
        found                = pick_s.found;
        idx                  = IW'(pick_s.idx);
    end

endmodule

// File: rtl/adder16_share_sched.sv
// Shares one carry_select_adder16 among NREQ requesters with round-robin
// arbitration. A burst (beats until last=1) locks the adder to its owner and
// chains each beat's carry out into the next beat's carry in.
// Ports: clk, rst (async, active-high); per-requester req_valid/req_ready,
//        req_a/req_b (16 bits each, requester i at [16*i+:16]), req_cin,
//        req_last; result register rsp_valid/rsp_ready, rsp_id, rsp_sum,
//        rsp_cout, rsp_last (1-cycle latency, holds under backpressure).
module adder16_share_sched
    import adder16_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
    input  logic [NREQ-1:0]        req_last,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WORD_W-1:0]      rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_last
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t      state_r;
    sched_state_t      state_nxt_s;
    logic [IW-1:0]     rr_ptr_r;
    logic [IW-1:0]     lock_id_r;
    logic              carry_q_r;

    logic              rsp_valid_r;
    logic [IDW-1:0]    rsp_id_r;
    logic [WORD_W-1:0] rsp_sum_r;
    logic              rsp_cout_r;
    logic              rsp_last_r;

    logic              grant_found_s;
    logic [IW-1:0]     grant_idx_s;
    logic [IW-1:0]     sel_idx_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic              slot_free_s;
    logic              accept_s;
    logic [IW-1:0]     rr_next_s;
    logic [WORD_W-1:0] add_a_s;
    logic [WORD_W-1:0] add_b_s;
    logic              add_cin_s;
    logic [WORD_W-1:0] add_sum_s;
    logic              add_cout_s;

    rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .found (grant_found_s),
        .idx   (grant_idx_s)
    );

    carry_select_adder16 u_add (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a non-last beat locks, a last beat in a lock unlocks.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !sel_last_s) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (accept_s && sel_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: grant selection, adder operand mux and req_ready.
    always_comb begin
        slot_free_s = !rsp_valid_r || rsp_ready;
        case (state_r)
            IDLE: begin
                sel_idx_s   = grant_idx_s;
                sel_valid_s = grant_found_s;
                add_cin_s   = req_cin[grant_idx_s];
            end
            LOCKED: begin
                // Mid-burst the carry comes from the previous beat only.
                sel_idx_s   = lock_id_r;
                sel_valid_s = req_valid[lock_id_r];
                add_cin_s   = carry_q_r;
            end
            default: begin
                sel_idx_s   = grant_idx_s;
                sel_valid_s = 1'b0;
                add_cin_s   = 1'b0;
            end
        endcase
        sel_last_s = req_last[sel_idx_s];
        add_a_s    = req_a[sel_idx_s*WORD_W +: WORD_W];
        add_b_s    = req_b[sel_idx_s*WORD_W +: WORD_W];
        // Gating with rst keeps grants off while reset is asserted.
        accept_s   = sel_valid_s && slot_free_s && !rst;
        req_ready  = {NREQ{1'b0}};
        if (accept_s) begin
            req_ready[sel_idx_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
        if (sel_idx_s == IW'(NREQ - 1)) begin
            rr_next_s = {IW{1'b0}};
        end else begin
            rr_next_s = sel_idx_s + IW'(1);
        end
    end

    // Burst context: chained carry, lock owner and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q_r <= 1'b0;
            lock_id_r <= {IW{1'b0}};
            rr_ptr_r  <= {IW{1'b0}};
        end else if (accept_s) begin
            carry_q_r <= add_cout_s;
            if (state_r == IDLE && !sel_last_s) begin
                lock_id_r <= sel_idx_s;
            end
            // Pointer moves only when a burst completes.
            if (sel_last_s) begin
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    // Result register: loads on accept, empties when drained with no accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_sum_r   <= {WORD_W{1'b0}};
            rsp_cout_r  <= 1'b0;
            rsp_last_r  <= 1'b0;
        end else if (slot_free_s) begin
            rsp_valid_r <= accept_s;
            if (accept_s) begin
                rsp_id_r   <= IDW'(sel_idx_s);
                rsp_sum_r  <= add_sum_s;
                rsp_cout_r <= add_cout_s;
                rsp_last_r <= sel_last_s;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_last  = rsp_last_r;

endmodule

// File: tb/tb_adder16_share_sched.sv
module tb_adder16_share_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  req_last;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_last;

    int errors;
    int checks;

    adder16_share_sched #(.NREQ(4), .IDW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        req_valid = 4'd0;
        req_a     = 64'd0;
        req_b     = 64'd0;
        req_cin   = 4'd0;
        req_last  = 4'd0;
    endtask

    task automatic set_beat(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic last, input logic v);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_cin[i]        = cin;
        req_last[i]       = last;
        req_valid[i]      = v;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_reqs();
        rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_beat(0, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1);
        set_beat(2, 16'h0002, 16'h0002, 1'b0, 1'b1, 1'b1);
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", rsp_sum); end
        checks++; if ({rsp_id, rsp_cout, rsp_last} !== 5'b00000) begin errors++; $display("FAIL reset_id_cout_last: got %b want 00000", {rsp_id, rsp_cout, rsp_last}); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        clear_reqs();
        rst = 1'b0;
    endtask

    task automatic test_single_beat;
        do_reset();
        set_beat(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'd0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_sum !== 16'h0000) begin errors++; $display("FAIL single_sum: got %h want 0000", rsp_sum); end
        checks++; if (rsp_cout !== 1'b1) begin errors++; $display("FAIL single_cout: got %b want 1", rsp_cout); end
        checks++; if (rsp_id !== 3'd0 || rsp_last !== 1'b1) begin errors++; $display("FAIL single_id_last: got id=%0d last=%b want id=0 last=1", rsp_id, rsp_last); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin;
        int          ord[5];
        logic [15:0] exp_sum;
        ord = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_beat(i, 16'((i + 1) * 4096), 16'(i), 1'b0, 1'b1, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << ord[k])) begin errors++; $display("FAIL rr_ready_%0d: got %b want %b", k, req_ready, 4'b0001 << ord[k]); end
            tick();
            exp_sum = 16'((ord[k] + 1) * 4096 + ord[k]);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'(ord[k]) || rsp_sum !== exp_sum) begin
                errors++; $display("FAIL rr_rsp_%0d: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", k, rsp_valid, rsp_id, rsp_sum, ord[k], exp_sum);
            end
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_burst;
        do_reset();
        set_beat(2, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL burst_ready1: got %b want 0100", req_ready); end
        tick();
        checks++; if (rsp_sum !== 16'h0001 || rsp_cout !== 1'b1 || rsp_id !== 3'd2 || rsp_last !== 1'b0) begin
            errors++; $display("FAIL burst_beat1: got sum=%h cout=%b id=%0d last=%b want 0001 1 2 0", rsp_sum, rsp_cout, rsp_id, rsp_last);
        end
        set_beat(0, 16'h1111, 16'h0000, 1'b0, 1'b1, 1'b1);
        set_beat(1, 16'h2222, 16'h0000, 1'b0, 1'b1, 1'b1);
        set_beat(2, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL burst_ready2: got %b want 0100", req_ready); end
        tick();
        checks++; if (rsp_sum !== 16'h0001 || rsp_cout !== 1'b0 || rsp_id !== 3'd2 || rsp_last !== 1'b1) begin
            errors++; $display("FAIL burst_beat2: got sum=%h cout=%b id=%0d last=%b want 0001 0 2 1", rsp_sum, rsp_cout, rsp_id, rsp_last);
        end
        req_valid[2] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL burst_after_ready: got %b want 0001", req_ready); end
        tick();
        checks++; if (rsp_id !== 3'd0 || rsp_sum !== 16'h1111) begin errors++; $display("FAIL burst_after_rsp: got id=%0d sum=%h want 0 1111", rsp_id, rsp_sum); end
        clear_reqs();
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        rsp_ready = 1'b0;
        set_beat(1, 16'h1234, 16'h1111, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready: got %b want 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        set_beat(3, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1);
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h2345) begin errors++; $display("FAIL bp_first_rsp: got v=%b sum=%h want 1 2345", rsp_valid, rsp_sum); end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready_%0d: got %b want 0000", c, req_ready); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h2345 || rsp_id !== 3'd1 || rsp_cout !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b sum=%h id=%0d cout=%b want 1 2345 1 0", c, rsp_valid, rsp_sum, rsp_id, rsp_cout);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready: got %b want 1000", req_ready); end
        tick();
        clear_reqs();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0000 || rsp_cout !== 1'b1 || rsp_id !== 3'd3) begin
            errors++; $display("FAIL bp_release_rsp: got v=%b sum=%h cout=%b id=%0d want 1 0000 1 3", rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_lock_stall;
        do_reset();
        set_beat(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_first_ready: got %b want 0010", req_ready); end
        tick();
        checks++; if (rsp_sum !== 16'h0100 || rsp_cout !== 1'b0 || rsp_last !== 1'b0) begin errors++; $display("FAIL lock_first_rsp: got sum=%h cout=%b last=%b want 0100 0 0", rsp_sum, rsp_cout, rsp_last); end
        req_valid[1] = 1'b0;
        set_beat(3, 16'h5555, 16'h1111, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lock_stall_ready_%0d: got %b want 0000", c, req_ready); end
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lock_stall_valid_%0d: got %b want 0", c, rsp_valid); end
        end
        set_beat(1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lock_resume_ready: got %b want 0010", req_ready); end
        tick();
        checks++; if (rsp_sum !== 16'hFFFF || rsp_cout !== 1'b0 || rsp_id !== 3'd1 || rsp_last !== 1'b1) begin
            errors++; $display("FAIL lock_resume_rsp: got sum=%h cout=%b id=%0d last=%b want FFFF 0 1 1", rsp_sum, rsp_cout, rsp_id, rsp_last);
        end
        req_valid[1] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lock_next_ready: got %b want 1000", req_ready); end
        tick();
        checks++; if (rsp_id !== 3'd3 || rsp_sum !== 16'h6666) begin errors++; $display("FAIL lock_next_rsp: got id=%0d sum=%h want 3 6666", rsp_id, rsp_sum); end
        clear_reqs();
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        rsp_ready = 1'b0;
        set_beat(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL arst_first_ready: got %b want 0010", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0000 || rsp_cout !== 1'b1) begin
            errors++; $display("FAIL arst_first_rsp: got v=%b sum=%h cout=%b want 1 0000 1", rsp_valid, rsp_sum, rsp_cout);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL arst_ready: got %b want 0000", req_ready); end
        #1;
        rst = 1'b0;
        set_beat(1, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1);
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL arst_fresh_ready: got %b want 0010", req_ready); end
        tick();
        checks++; if (rsp_sum !== 16'h0002 || rsp_cout !== 1'b0 || rsp_id !== 3'd1 || rsp_last !== 1'b1) begin
            errors++; $display("FAIL arst_fresh_rsp: got sum=%h cout=%b id=%0d last=%b want 0002 0 1 1", rsp_sum, rsp_cout, rsp_id, rsp_last);
        end
        clear_reqs();
        tick();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        clear_reqs();
        test_reset();
        test_single_beat();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_lock_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
